// File: rtl/pix_frame_writer.sv
// Pixel stream to frame RAM writer: s_sof anchors address 0, addresses increment per pixel.
// Optional resync error counter is enabled by defining PIXWR_ERRCNT_EN.
module pix_frame_writer #(
  parameter int unsigned IMG_W = 200,
  parameter int unsigned IMG_H = 200
) (
  input  logic        clkq,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  input  logic [5:0]  s_r,
  input  logic [5:0]  s_g,
  input  logic [5:0]  s_b,
  output logic        we,
  output logic [15:0] waddr,
  output logic [5:0]  wd_r,
  output logic [5:0]  wd_g,
  output logic [5:0]  wd_b,
  output logic [15:0] line_cnt,
  output logic        frame_done,
  output logic [7:0]  err_cnt
);

  localparam logic [15:0] LAST_ADDR = 16'(IMG_W * IMG_H - 1);
  localparam logic [15:0] COL_LAST  = 16'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t      state;
  logic [15:0] col;
  logic [15:0] next_addr;
  logic        accept;

  assign accept    = s_valid & s_ready;
  assign next_addr = waddr + 16'd1;

  always_ff @(posedge clkq or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      col        <= '0;
      line_cnt   <= '0;
      wd_r       <= '0;
      wd_g       <= '0;
      wd_b       <= '0;
      frame_done <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      s_ready    <= 1'b1;
      if (state == DONE) begin
        state <= IDLE;
      end else if (accept && (s_sof || state == WRITE)) begin
        we    <= 1'b1;
        wd_r  <= s_r;
        wd_g  <= s_g;
        wd_b  <= s_b;
        state <= WRITE;
        // s_sof takes priority over the final-address check, so a late resync never ends the frame
        if (s_sof) begin
          waddr    <= '0;
          col      <= '0;
          line_cnt <= '0;
        end else begin
          waddr <= next_addr;
          if (col == COL_LAST) begin
            col      <= '0;
            line_cnt <= line_cnt + 16'd1;
          end else begin
            col <= col + 16'd1;
          end
          if (next_addr == LAST_ADDR) begin
            frame_done <= 1'b1;
            s_ready    <= 1'b0;
            state      <= DONE;
          end
        end
      end
    end
  end

`ifdef PIXWR_ERRCNT_EN
  logic resync;
  assign resync = accept & s_sof & (state == WRITE);

  always_ff @(posedge clkq or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (resync && err_cnt != '1) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pix_frame_writer.sv
// Self-checking bench for pix_frame_writer: random pixel streams against a pixel-index model,
// plus a small-frame instance for the s_sof-on-final-address corner.
module tb_pix_frame_writer;

  localparam int unsigned W    = 200;
  localparam int unsigned H    = 200;
  localparam int unsigned NPIX = W * H;

  logic        clkq = 1'b0;
  logic        rst_n;
  logic        s_valid, s_sof, s_ready;
  logic [5:0]  s_r, s_g, s_b;
  logic        we, frame_done;
  logic [15:0] waddr, line_cnt;
  logic [5:0]  wd_r, wd_g, wd_b;
  logic [7:0]  err_cnt;

  logic        t_valid, t_sof, t_ready;
  logic [5:0]  t_r;
  logic        t_we, t_fd;
  logic [15:0] t_waddr, t_line;
  logic [5:0]  t_wd_r, t_wd_g, t_wd_b;
  logic [7:0]  t_err;

  always #5 clkq = ~clkq;

  pix_frame_writer #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clkq(clkq), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_r(s_r), .s_g(s_g), .s_b(s_b), .we(we), .waddr(waddr),
    .wd_r(wd_r), .wd_g(wd_g), .wd_b(wd_b), .line_cnt(line_cnt),
    .frame_done(frame_done), .err_cnt(err_cnt)
  );

  pix_frame_writer #(.IMG_W(4), .IMG_H(3)) u_small (
    .clkq(clkq), .rst_n(rst_n), .s_valid(t_valid), .s_ready(t_ready), .s_sof(t_sof),
    .s_r(t_r), .s_g(6'h15), .s_b(6'h2A), .we(t_we), .waddr(t_waddr),
    .wd_r(t_wd_r), .wd_g(t_wd_g), .wd_b(t_wd_b), .line_cnt(t_line),
    .frame_done(t_fd), .err_cnt(t_err)
  );

  int nchecks = 0;
  int npass   = 0;

  // Reference model: position of the last written pixel within the current frame
  logic        m_ready, m_inframe;
  int          m_idx, m_resync;
  logic        e_we, e_fd;
  logic [15:0] e_addr, e_line;
  logic [17:0] e_wd;

  int          bad;
  logic [60:0] bad_obs, bad_exp;

  function automatic logic [7:0] exp_err();
`ifdef PIXWR_ERRCNT_EN
    return (m_resync > 255) ? 8'd255 : 8'(m_resync);
`else
    return 8'(m_resync * 0);
`endif
  endfunction

  function automatic logic [60:0] obs_vec();
    return {s_ready, we, waddr, line_cnt, wd_r, wd_g, wd_b, frame_done, err_cnt};
  endfunction

  function automatic logic [60:0] exp_vec();
    return {m_ready, e_we, e_addr, e_line, e_wd, e_fd, exp_err()};
  endfunction

  function automatic logic [5:0] rc();
    return 6'($urandom_range(63));
  endfunction

  task automatic model_reset();
    m_ready = 1'b0; m_inframe = 1'b0; m_idx = 0; m_resync = 0;
    e_we = 1'b0; e_fd = 1'b0; e_addr = '0; e_line = '0; e_wd = '0;
  endtask

  // Drive one cycle, advance the model, and record any divergence in bad
  task automatic step(input logic v, input logic sof, input logic [5:0] r, input logic [5:0] g,
                      input logic [5:0] b);
    logic acc;
    s_valid = v; s_sof = sof; s_r = r; s_g = g; s_b = b;
    acc = v && m_ready;
    @(posedge clkq); #1;
    e_we = 1'b0; e_fd = 1'b0;
    if (!m_ready) begin
      m_ready = 1'b1;
    end else if (acc && (sof || m_inframe)) begin
      if (sof) begin
        if (m_inframe) m_resync++;
        m_inframe = 1'b1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
      e_we = 1'b1; e_addr = 16'(m_idx); e_line = 16'(m_idx / W); e_wd = {r, g, b};
      if (!sof && m_idx == NPIX - 1) begin
        e_fd = 1'b1; m_inframe = 1'b0; m_ready = 1'b0;
      end
    end
    if (obs_vec() !== exp_vec()) begin
      if (bad == 0) begin bad_obs = obs_vec(); bad_exp = exp_vec(); end
      bad++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_r = '0; s_g = '0; s_b = '0;
    t_valid = 1'b0; t_sof = 1'b0; t_r = '0;
    repeat (2) @(posedge clkq);
    #1 rst_n = 1'b1;
    model_reset();
    bad = 0;
    step(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_r = '0; s_g = '0; s_b = '0;
    t_valid = 1'b0; t_sof = 1'b0; t_r = '0;
    repeat (2) @(posedge clkq);
    #1;
    nchecks++;
    if (obs_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", obs_vec());
    else npass++;
    rst_n = 1'b1;
    model_reset();
    bad = 0;
    #2;
    nchecks++;
    if (s_ready !== 1'b0) $display("FAIL reset_ready_before_edge: got %b want 0", s_ready);
    else npass++;
    step(1'b0, 1'b0, '0, '0, '0);
    nchecks++;
    if (s_ready !== 1'b1) $display("FAIL reset_ready_after_edge: got %b want 1", s_ready);
    else npass++;
  endtask

  task automatic test_full_frame();
    int nwe = 0, nfd = 0;
    logic [15:0] fd_addr = '0, fd_line = '0;
    logic rdy_last = 1'b1;
    do_reset();
    for (int i = 0; i < int'(NPIX); i++) begin
      step(1'b1, i == 0, rc(), rc(), rc());
      if (we === 1'b1) nwe++;
      if (frame_done === 1'b1) begin nfd++; fd_addr = waddr; fd_line = line_cnt; end
      if (i == int'(NPIX) - 1) rdy_last = s_ready;
    end
    nchecks++;
    if (nwe != 40000) $display("FAIL full_frame_we_count: got %0d want 40000", nwe);
    else npass++;
    nchecks++;
    if (nfd != 1) $display("FAIL full_frame_done_count: got %0d want 1", nfd);
    else npass++;
    nchecks++;
    if (fd_addr !== 16'd39999) $display("FAIL full_frame_done_addr: got %0d want 39999", fd_addr);
    else npass++;
    nchecks++;
    if (fd_line !== 16'd199) $display("FAIL full_frame_done_line: got %0d want 199", fd_line);
    else npass++;
    nchecks++;
    if (rdy_last !== 1'b0) $display("FAIL full_frame_done_ready: got %b want 0", rdy_last);
    else npass++;
    step(1'b1, 1'b1, rc(), rc(), rc());
    nchecks++;
    if (s_ready !== 1'b1 || we !== 1'b0)
      $display("FAIL full_frame_ready_return: got ready=%b we=%b want ready=1 we=0", s_ready, we);
    else npass++;
    nchecks++;
    if (bad != 0) $display("FAIL full_frame_stream: got %h want %h (%0d bad cycles)", bad_obs, bad_exp, bad);
    else npass++;
  endtask

  task automatic test_idle_drop();
    int nwe = 0;
    logic [5:0] r, g, b;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, rc(), rc(), rc());
      if (we !== 1'b0) nwe++;
    end
    nchecks++;
    if (nwe != 0) $display("FAIL idle_drop_no_write: got %0d writes want 0", nwe);
    else npass++;
    r = rc(); g = rc(); b = rc();
    step(1'b1, 1'b1, r, g, b);
    nchecks++;
    if (we !== 1'b1 || waddr !== 16'd0)
      $display("FAIL idle_drop_first_write: got we=%b waddr=%0d want we=1 waddr=0", we, waddr);
    else npass++;
    nchecks++;
    if ({wd_r, wd_g, wd_b} !== {r, g, b})
      $display("FAIL idle_drop_first_data: got %h want %h", {wd_r, wd_g, wd_b}, {r, g, b});
    else npass++;
  endtask

  task automatic test_resync();
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, i == 0, rc(), rc(), rc());
    step(1'b1, 1'b1, rc(), rc(), rc());
    nchecks++;
    if (we !== 1'b1 || waddr !== 16'd0)
      $display("FAIL resync_addr: got we=%b waddr=%0d want we=1 waddr=0", we, waddr);
    else npass++;
    nchecks++;
    if (line_cnt !== 16'd0) $display("FAIL resync_line: got %0d want 0", line_cnt);
    else npass++;
    nchecks++;
`ifdef PIXWR_ERRCNT_EN
    if (err_cnt !== 8'd1) $display("FAIL resync_err_cnt: got %0d want 1", err_cnt);
`else
    if (err_cnt !== 8'd0) $display("FAIL resync_err_cnt: got %0d want 0", err_cnt);
`endif
    else npass++;
    step(1'b1, 1'b0, rc(), rc(), rc());
    nchecks++;
    if (bad != 0) $display("FAIL resync_stream: got %h want %h (%0d bad cycles)", bad_obs, bad_exp, bad);
    else npass++;
  endtask

  task automatic test_valid_toggle();
    int nwe = 0;
    do_reset();
    step(1'b1, 1'b1, rc(), rc(), rc());
    if (we === 1'b1) nwe++;
    for (int i = 0; i < 60; i++) begin
      step(i % 2 == 0, 1'b0, rc(), rc(), rc());
      if (we === 1'b1) nwe++;
    end
    nchecks++;
    if (nwe != 31) $display("FAIL toggle_write_count: got %0d want 31", nwe);
    else npass++;
    nchecks++;
    if (waddr !== 16'd30) $display("FAIL toggle_final_addr: got %0d want 30", waddr);
    else npass++;
    nchecks++;
    if (bad != 0) $display("FAIL toggle_stream: got %h want %h (%0d bad cycles)", bad_obs, bad_exp, bad);
    else npass++;
  endtask

  task automatic test_line_wrap();
    do_reset();
    for (int i = 0; i < 201; i++) step(1'b1, i == 0, rc(), rc(), rc());
    step(1'b1, 1'b0, 6'h2A, rc(), rc());
    nchecks++;
    if (we !== 1'b1 || waddr !== 16'd201 || line_cnt !== 16'd1 || wd_r !== 6'h2A)
      $display("FAIL line_wrap_pixel201: got we=%b waddr=%0d line=%0d wd_r=%h want we=1 waddr=201 line=1 wd_r=2a",
               we, waddr, line_cnt, wd_r);
    else npass++;
    nchecks++;
    if (bad != 0) $display("FAIL line_wrap_stream: got %h want %h (%0d bad cycles)", bad_obs, bad_exp, bad);
    else npass++;
  endtask

  task automatic test_reset_midframe();
    int nwe = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) step(1'b1, i == 0, rc(), rc(), rc());
    nchecks++;
    if (bad != 0) $display("FAIL midframe_stream: got %h want %h (%0d bad cycles)", bad_obs, bad_exp, bad);
    else npass++;
    rst_n = 1'b0;
    #1;
    nchecks++;
    if (obs_vec() !== '0) $display("FAIL midframe_reset_outputs: got %h want 0", obs_vec());
    else npass++;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, rc(), rc(), rc());
      if (we !== 1'b0) nwe++;
    end
    nchecks++;
    if (nwe != 0) $display("FAIL midframe_no_resume: got %0d writes want 0", nwe);
    else npass++;
    step(1'b1, 1'b1, rc(), rc(), rc());
    nchecks++;
    if (we !== 1'b1 || waddr !== 16'd0)
      $display("FAIL midframe_restart: got we=%b waddr=%0d want we=1 waddr=0", we, waddr);
    else npass++;
  endtask

  // 4x3 frame: final address is 11
  task automatic test_sof_at_last();
    int bad_s = 0, nfd = 0;
    logic rdy_last = 1'b1;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      t_valid = 1'b1; t_sof = (i == 0); t_r = 6'(i);
      @(posedge clkq); #1;
      if (!(t_we === 1'b1 && t_waddr === 16'(i) && t_line === 16'(i / 4))) bad_s++;
      if (t_fd === 1'b1) nfd++;
    end
    t_sof = 1'b1; t_r = 6'h3F;
    @(posedge clkq); #1;
    nchecks++;
    if (t_we !== 1'b1 || t_waddr !== 16'd0 || t_fd !== 1'b0 || t_wd_r !== 6'h3F)
      $display("FAIL sof_last_resync: got we=%b waddr=%0d fd=%b wd_r=%h want we=1 waddr=0 fd=0 wd_r=3f",
               t_we, t_waddr, t_fd, t_wd_r);
    else npass++;
    nchecks++;
    if (t_ready !== 1'b1) $display("FAIL sof_last_ready: got %b want 1", t_ready);
    else npass++;
    nchecks++;
`ifdef PIXWR_ERRCNT_EN
    if (t_err !== 8'd1) $display("FAIL sof_last_err_cnt: got %0d want 1", t_err);
`else
    if (t_err !== 8'd0) $display("FAIL sof_last_err_cnt: got %0d want 0", t_err);
`endif
    else npass++;
    t_sof = 1'b0;
    for (int i = 1; i < 12; i++) begin
      t_r = 6'(i);
      @(posedge clkq); #1;
      if (!(t_we === 1'b1 && t_waddr === 16'(i) && t_line === 16'(i / 4) && t_wd_r === 6'(i)
            && t_wd_g === 6'h15 && t_wd_b === 6'h2A)) bad_s++;
      if (t_fd === 1'b1) nfd++;
      if (i == 11) rdy_last = t_ready;
    end
    nchecks++;
    if (bad_s != 0) $display("FAIL small_stream: got %0d bad cycles want 0", bad_s);
    else npass++;
    nchecks++;
    if (nfd != 1) $display("FAIL small_done_count: got %0d want 1", nfd);
    else npass++;
    nchecks++;
    if (rdy_last !== 1'b0) $display("FAIL small_done_ready: got %b want 0", rdy_last);
    else npass++;
    t_valid = 1'b0;
    @(posedge clkq); #1;
    nchecks++;
    if (t_ready !== 1'b1 || t_we !== 1'b0)
      $display("FAIL small_ready_return: got ready=%b we=%b want ready=1 we=0", t_ready, t_we);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_idle_drop();
    test_resync();
    test_valid_toggle();
    test_line_wrap();
    test_reset_midframe();
    test_sof_at_last();
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
